// File: rtl/alu_pkg.sv
// ============================================================================
// Package     : alu_pkg
// Description : Shared definitions for the serial ALU sequencer: ALU op
//               encodings, nibble width, sequencer state type and a helper
//               for sizing the nibble index counter.
// Contents    : OP_PASS/OP_ADD/OP_AND/OP_NOT, NIB_W, state_t, idx_width()
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   // Width of one ALU slice.
   localparam int NIB_W = 4;

   // ALU select encodings.
   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_NOT  = 2'b11;

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of a counter that must hold 0..nib-1; never narrower than 1 bit.
   function automatic int idx_width(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_serial_ctrl_if.sv
// ============================================================================
// Interface   : alu_serial_ctrl_if
// Description : Operand request and result handshake bundle of the serial
//               ALU sequencer.
// Signals     : in_valid/in_ready/in_op/in_a/in_b/in_cin   operand request
//               out_valid/out_ready/out_f/out_cout          result
// Modports    : master - producer/consumer side
//               slave  - sequencer side
// Parameters  : W - operand/result word width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_serial_ctrl_if #(
   parameter int W = 16
);

   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_op;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_f;
   logic          out_cout;

   modport master (
      output in_valid, in_op, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_f, out_cout
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_f, out_cout
   );

endinterface

`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
// ============================================================================
// Module      : alu_serial_ctrl
// Description : Drives an external 4-bit combinational ALU one nibble per
//               clock to execute NIB x 4-bit operations. The ripple carry is
//               held in a flop between nibbles.
// Ports       : clk              clock, rising edge
//               rst_n            asynchronous active-low reset
//               bus (slave)      operand request / result handshake
//               alu_sel          ALU op select (00 outside RUN)
//               alu_a, alu_b     ALU operand nibbles (0 outside RUN)
//               alu_cin          ALU carry-in (0 unless ADD in RUN)
//               alu_f, alu_cout  ALU result nibble and carry-out
// Parameters  : NIB - nibbles per operand (1..16), word width 4*NIB
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter int NIB = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_serial_ctrl_if.slave bus,
   output logic [1:0]       alu_sel,
   output logic [NIB_W-1:0] alu_a,
   output logic [NIB_W-1:0] alu_b,
   output logic             alu_cin,
   input  logic [NIB_W-1:0] alu_f,
   input  logic             alu_cout
);

   localparam int W     = NIB_W * NIB;
   localparam int IDX_W = idx_width(NIB);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;
   logic [1:0]          op_q,    op_d;
   logic [W-1:0]        a_q,     a_d;
   logic [W-1:0]        b_q,     b_d;
   logic                cin_q,   cin_d;
   logic                carry_q, carry_d;
   logic [W-1:0]        f_q,     f_d;

   logic [NIB_W-1:0]    nib_a;
   logic [NIB_W-1:0]    nib_b;
   logic                last_nib;

   assign last_nib = (idx_q == IDX_LAST);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.in_valid)  state_d = RUN;
         RUN:  if (last_nib)      state_d = DONE;
         DONE: if (bus.out_ready) state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Operand nibble select for the current index
   // ------------------------------------------------------------------------
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int k = 0; k < NIB; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib_a = a_q[k*NIB_W +: NIB_W];
            nib_b = b_q[k*NIB_W +: NIB_W];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Datapath next-state
   // ------------------------------------------------------------------------
   always_comb begin
      idx_d   = idx_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      carry_d = carry_q;
      f_d     = f_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d    = bus.in_op;
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               cin_d   = bus.in_cin;
               idx_d   = '0;
               f_d     = '0;
               // Clearing here keeps a carry from leaking into the next op.
               carry_d = 1'b0;
            end
         end
         RUN: begin
            // The ALU already gates cout for non-ADD ops; gating again keeps
            // out_cout at 0 even if a different ALU is paired with us.
            carry_d = (op_q == OP_ADD) & alu_cout;
            for (int k = 0; k < NIB; k++) begin
               if (idx_q == IDX_W'(k)) begin
                  f_d[k*NIB_W +: NIB_W] = alu_f;
               end
            end
            // Index parks on the last nibble rather than wrapping.
            if (!last_nib) begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         op_q    <= OP_PASS;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         f_q     <= '0;
      end else begin
         idx_q   <= idx_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         carry_q <= carry_d;
         f_q     <= f_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: output decode (state and registers only, no input feed-through)
   // ------------------------------------------------------------------------
   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.out_f     = f_q;
      bus.out_cout  = carry_q;
      alu_sel       = OP_PASS;
      alu_a         = '0;
      alu_b         = '0;
      alu_cin       = 1'b0;
      if (state_q == RUN) begin
         alu_sel = op_q;
         alu_a   = nib_a;
         alu_b   = nib_b;
         // Nibble 0 takes the request carry, later nibbles the rippled one.
         if (op_q == OP_ADD) begin
            alu_cin = (idx_q == '0) ? cin_q : carry_q;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
// ============================================================================
// Module      : tb_alu_serial_ctrl
// Description : Self-checking bench for alu_serial_ctrl paired with a 4-bit
//               ALU model. Expected results go into a scoreboard queue when
//               a request is driven and are compared when a result is taken.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_serial_ctrl;
   import alu_pkg::*;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- 4-bit ALU model ----------------
   function automatic logic [4:0] alu4(input logic [1:0] s, input logic [3:0] a,
                                       input logic [3:0] b, input logic c);
      case (s)
         OP_PASS: return {1'b0, a};
         OP_ADD:  return {1'b0, a} + {1'b0, b} + {4'b0, c};
         OP_AND:  return {1'b0, a & b};
         default: return {1'b0, ~a};
      endcase
   endfunction

   // ---------------- DUT, NIB=4 ----------------
   alu_serial_ctrl_if #(.W(W)) bus0();
   logic [1:0] a0_sel;
   logic [3:0] a0_a, a0_b, a0_f;
   logic       a0_cin, a0_cout;

   alu_serial_ctrl #(.NIB(NIB)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0),
      .alu_sel(a0_sel), .alu_a(a0_a), .alu_b(a0_b), .alu_cin(a0_cin),
      .alu_f(a0_f), .alu_cout(a0_cout)
   );
   assign {a0_cout, a0_f} = alu4(a0_sel, a0_a, a0_b, a0_cin);

   // ---------------- DUT, NIB=1 ----------------
   alu_serial_ctrl_if #(.W(4)) bus1();
   logic [1:0] a1_sel;
   logic [3:0] a1_a, a1_b, a1_f;
   logic       a1_cin, a1_cout;

   alu_serial_ctrl #(.NIB(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1),
      .alu_sel(a1_sel), .alu_a(a1_a), .alu_b(a1_b), .alu_cin(a1_cin),
      .alu_f(a1_f), .alu_cout(a1_cout)
   );
   assign {a1_cout, a1_f} = alu4(a1_sel, a1_a, a1_b, a1_cin);

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Word-level reference: W-bit modular add with carry out of the top bit.
   function automatic logic [W:0] ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
      case (op)
         OP_ADD:  return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         OP_AND:  return {1'b0, a & b};
         OP_NOT:  return {1'b0, ~a};
         default: return {1'b0, a};
      endcase
   endfunction

   // Carry expected into nibble k: carry out of the sum of the low k nibbles.
   function automatic logic ref_cin(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic cin, input int k);
      logic [31:0] mask, s;
      if (op != OP_ADD) return 1'b0;
      mask = (32'd1 << (4*k)) - 32'd1;
      s    = ({16'd0, a} & mask) + ({16'd0, b} & mask) + {31'd0, cin};
      return s[4*k];
   endfunction

   typedef struct packed {
      logic [W-1:0] f;
      logic         c;
   } res_t;

   res_t sb_q[$];

   // Result monitor: pops on every result handshake.
   always @(negedge clk) begin : mon
      res_t e;
      if (rst_n && bus0.out_valid && bus0.out_ready) begin
         chk("sb_depth", sb_q.size(), 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("out_f", bus0.out_f, e.f);
            chk("out_cout", bus0.out_cout, e.c);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin, input logic rdy);
      logic [W:0] r;
      bit seen;
      r = ref_res(op, a, b, cin);
      @(posedge clk); #1;
      bus0.out_ready = rdy;
      bus0.in_valid  = 1'b1;
      bus0.in_op     = op;
      bus0.in_a      = a;
      bus0.in_b      = b;
      bus0.in_cin    = cin;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus0.in_ready) begin
            seen = 1'b1;
            break;
         end
      end
      chk("accept_timeout", {31'd0, seen}, 1);
      sb_q.push_back('{f: r[W-1:0], c: r[W]});
      @(posedge clk); #1;
      bus0.in_valid = 1'b0;
   endtask

   task automatic do_op(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input int hold);
      logic [W:0] r;
      bit seen;
      int n;
      r = ref_res(op, a, b, cin);
      start_op(op, a, b, cin, (hold == 0));
      seen = 1'b0;
      n    = 0;
      for (int i = 1; i <= NIB + 4; i++) begin
         @(negedge clk);
         n = i;
         if (bus0.out_valid) begin
            seen = 1'b1;
            break;
         end
         if (i <= NIB) begin
            chk("alu_sel", a0_sel, op);
            chk("alu_a", a0_a, a[4*(i-1) +: 4]);
            chk("alu_b", a0_b, b[4*(i-1) +: 4]);
            chk("alu_cin", a0_cin, ref_cin(op, a, b, cin, i-1));
            chk("in_ready_run", bus0.in_ready, 0);
         end
      end
      chk("done_timeout", {31'd0, seen}, 1);
      chk("latency", n, NIB + 1);
      chk("alu_sel_done", a0_sel, OP_PASS);
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            chk("bp_valid", bus0.out_valid, 1);
            chk("bp_f", bus0.out_f, r[W-1:0]);
            chk("bp_cout", bus0.out_cout, r[W]);
            chk("bp_in_ready", bus0.in_ready, 0);
            @(posedge clk); #1;
            if (h < hold - 1) begin
               bus0.in_valid = 1'b1;
               bus0.in_op    = OP_NOT;
               bus0.in_a     = 16'h5555;
            end else begin
               bus0.in_valid  = 1'b0;
               bus0.out_ready = 1'b1;
            end
            @(negedge clk);
         end
         chk("bp_valid_release", bus0.out_valid, 1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("in_ready_after", bus0.in_ready, 1);
      chk("out_valid_after", bus0.out_valid, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [1:0]   b2b_op [3];
      logic [W-1:0] b2b_a  [3];
      logic [W-1:0] b2b_b  [3];
      logic         b2b_c  [3];
      logic [W:0]   r;
      int           acc[$];
      int           k;
      bit           seen;
      int           n;

      bus0.in_valid = 1'b0; bus0.in_op = 2'b00; bus0.in_a = '0; bus0.in_b = '0;
      bus0.in_cin = 1'b0; bus0.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.in_op = 2'b00; bus1.in_a = '0; bus1.in_b = '0;
      bus1.in_cin = 1'b0; bus1.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", bus0.in_ready, 1);
      chk("rst_out_valid", bus0.out_valid, 0);
      chk("rst_out_f", bus0.out_f, 0);
      chk("rst_out_cout", bus0.out_cout, 0);
      chk("rst_alu_sel", a0_sel, 0);
      chk("rst_alu_a", a0_a, 0);
      chk("rst_alu_b", a0_b, 0);
      chk("rst_alu_cin", a0_cin, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Main function
      do_op(OP_ADD,  16'hFFFF, 16'h0001, 1'b0, 0);
      do_op(OP_ADD,  16'h7FFF, 16'h0000, 1'b1, 0);
      do_op(OP_AND,  16'hF0F0, 16'h3C3C, 1'b1, 0);
      do_op(OP_NOT,  16'h1234, 16'h0000, 1'b0, 0);
      do_op(OP_PASS, 16'hABCD, 16'h5A5A, 1'b1, 0);

      // Backpressure: three DONE cycles with out_ready low
      do_op(OP_ADD,  16'h1234, 16'h1111, 1'b0, 3);

      // Reset in the second RUN cycle
      start_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("mid_run_sel", a0_sel, OP_ADD);
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("mrst_out_valid", bus0.out_valid, 0);
      chk("mrst_in_ready", bus0.in_ready, 1);
      chk("mrst_alu_sel", a0_sel, 0);
      chk("mrst_alu_a", a0_a, 0);
      chk("mrst_alu_b", a0_b, 0);
      chk("mrst_alu_cin", a0_cin, 0);
      chk("mrst_out_f", bus0.out_f, 0);
      chk("mrst_out_cout", bus0.out_cout, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_op(OP_ADD, 16'h0001, 16'h0001, 1'b0, 0);

      // Back-to-back with out_ready tied high
      b2b_op = '{OP_ADD, OP_AND, OP_PASS};
      b2b_a  = '{16'h1111, 16'hFF00, 16'h0F0F};
      b2b_b  = '{16'h2222, 16'h0FF0, 16'h0000};
      b2b_c  = '{1'b1, 1'b0, 1'b0};
      @(posedge clk); #1;
      bus0.out_ready = 1'b1;
      bus0.in_valid  = 1'b1;
      bus0.in_op = b2b_op[0]; bus0.in_a = b2b_a[0]; bus0.in_b = b2b_b[0]; bus0.in_cin = b2b_c[0];
      k = 0;
      for (int i = 0; i < 100 && k < 3; i++) begin
         @(negedge clk);
         if (bus0.in_ready) begin
            acc.push_back(cyc);
            r = ref_res(b2b_op[k], b2b_a[k], b2b_b[k], b2b_c[k]);
            sb_q.push_back('{f: r[W-1:0], c: r[W]});
            @(posedge clk); #1;
            k++;
            if (k < 3) begin
               bus0.in_op = b2b_op[k]; bus0.in_a = b2b_a[k];
               bus0.in_b  = b2b_b[k];  bus0.in_cin = b2b_c[k];
            end else begin
               bus0.in_valid = 1'b0;
            end
         end
      end
      bus0.in_valid = 1'b0;
      chk("b2b_count", k, 3);
      for (int i = 1; i < acc.size(); i++) begin
         chk("b2b_gap", acc[i] - acc[i-1], NIB + 2);
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0) break;
      end
      chk("b2b_drain", sb_q.size(), 0);

      // NIB=1 smoke test
      @(posedge clk); #1;
      bus1.in_valid = 1'b1; bus1.in_op = OP_ADD;
      bus1.in_a = 4'hF; bus1.in_b = 4'h1; bus1.in_cin = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus1.in_ready) begin
            seen = 1'b1;
            break;
         end
      end
      chk("n1_accept_timeout", {31'd0, seen}, 1);
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      seen = 1'b0;
      n    = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         n = i;
         if (bus1.out_valid) begin
            seen = 1'b1;
            break;
         end
         chk("n1_alu_a", a1_a, 4'hF);
         chk("n1_alu_cin", a1_cin, 0);
      end
      chk("n1_done_timeout", {31'd0, seen}, 1);
      chk("n1_latency", n, 2);
      chk("n1_out_f", bus1.out_f, 4'h0);
      chk("n1_out_cout", bus1.out_cout, 1);

      repeat (2) @(negedge clk);
      chk("sb_final", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Multi-nibble sequencer that drives the 4-bit, 2-bit-select combinational ALU one nibble per clock to execute N×4-bit operations with a ripple carry held in a flop between cycles. It sits directly upstream of the ALU, supplying sel, a, b and cin, and also consumes the ALU's f and cout. It presents a valid/ready operand interface to the producer and a valid/ready result interface to the consumer.

## Interface
- NIB, 4: number of 4-bit nibbles per operand. Word width W = 4·NIB. Legal range 1..16.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  2  op select: 00 pass A, 01 A+B+cin, 10 A AND B, 11 NOT A.
- in_a, in_b  in  W  operands.
- in_cin  in  1  carry-in; used only for op 01.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_f  out  W  result word.
- out_cout  out  1  final carry; 0 for every op except 01.
- alu_sel  out  2  to ALU select.
- alu_a, alu_b  out  4  to ALU operand nibbles.
- alu_cin  out  1  to ALU carry-in.
- alu_f  in  4  from ALU result nibble.
- alu_cout  in  1  from ALU carry-out. The ALU already gates this to 0 unless sel=01.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is 1, capture op, a, b and cin into registers, clear nibble index idx=0, clear out_f, and go to RUN.
- RUN:
  - in_ready=0.
  - Combinational drive: alu_sel=op_q, alu_a=a_q[4·idx+:4], alu_b=b_q[4·idx+:4].
  - alu_cin = (idx==0 ? cin_q : carry_q) when op_q=01; otherwise alu_cin=0.
  - Each cycle: out_f[4·idx+:4] ← alu_f and carry_q ← alu_cout.
  - When idx=NIB−1, go to DONE. Otherwise idx ← idx+1.
- DONE:
  - out_valid=1. out_f and out_cout (= carry_q) are held stable.
  - When out_ready is 1, go to IDLE.
  - in_valid is ignored; the producer holds its request.
- Outside RUN: alu_sel=00, alu_a=0, alu_b=0, alu_cin=0, so the ALU is quiet.
- Arithmetic: an ADD is W-bit modular. out_cout is the carry out of the top nibble. Carry never leaks between transactions; carry_q is cleared on capture.
- Reset (asynchronous, including mid-RUN or mid-DONE):
  - state=IDLE, idx=0, all captured registers 0, carry_q=0.
  - Outputs: out_f=0, out_cout=0, out_valid=0, in_ready=1, all alu_* outputs 0.
  - Any in-flight transaction is discarded.
- idx is ⌈log2 NIB⌉ bits (min 1). It never wraps past NIB−1.

## Timing
- Accept edge = edge at which in_valid & in_ready are both 1 (call it edge 0).
- RUN occupies cycles 1..NIB. Nibble k is presented to the ALU in cycle k+1.
- out_valid rises after edge NIB; it is first seen in cycle NIB+1.
- Latency from accept to result = NIB+1 cycles.
- Result consumed on the edge where out_valid & out_ready are both 1. in_ready is 1 from the following cycle.
- Maximum throughput: one op per NIB+2 cycles with out_ready tied high.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid are decoded from state only.
- The ALU path is combinational. The alu_* → alu_f/alu_cout → flop path must close in one cycle.

## Structure
- Shared package alu_pkg:
  - op encoding constants OP_PASS=2'b00, OP_ADD=2'b01, OP_AND=2'b10, OP_NOT=2'b11.
  - State typedef {IDLE, RUN, DONE}.
  - Nibble width constant 4.
- No sub-module. Counter, datapath registers and FSM are inline.
- The ALU is instantiated beside this block by the parent, not inside it.
- Bench pairs this block with the existing 4-bit ALU.

## Test plan
- ADD, NIB=4, a=16'hFFFF, b=16'h0001, cin=0 → out_f=16'h0000, out_cout=1; out_valid first high 5 cycles after accept.
- ADD, a=16'h7FFF, b=16'h0000, cin=1 → out_f=16'h8000, out_cout=0. alu_cin=1 only in the first RUN cycle, then carries propagate.
- AND, a=16'hF0F0, b=16'h3C3C, cin=1 → out_f=16'h3030, out_cout=0, alu_cin=0 in every RUN cycle. NOT, a=16'h1234 → 16'hEDCB. PASS, a=16'hABCD → 16'hABCD.
- Backpressure: out_ready held 0 for 3 cycles in DONE → out_f and out_cout stable, in_ready=0, in_valid pulses ignored. Result is consumed on the first out_ready=1; in_ready=1 next cycle.
- Reset asserted in the 2nd RUN cycle of an ADD → immediately: out_valid=0, in_ready=1, alu_* outputs 0. The next ADD 16'h0001+16'h0001 returns 16'h0002 with no stale carry.
- Back-to-back ops with out_ready tied 1 → accepts spaced exactly NIB+2 cycles apart. NIB=1 smoke test: ADD 4'hF+4'h1 → 4'h0, cout=1.
